xbar_rr_scheduler: RTL
======================

Name: xbar_rr_scheduler

Overview:
- Per-output round-robin scheduler for the NxN crossbar.
- Each output port arbitrates among the input ports whose requested destination matches it.
- The winning input is locked to that output until its packet ends (in_last), and the scheduler drives the per-output route index consumed by the barrel_shifter select decoder.
- Sits between the input-port queues and the crossbar datapath, and gates input ready with output backpressure.

Parameters:
- N, 8, number of input ports and number of output ports (N >= 2).
- ROUTE_BITS, $clog2(N), localparam; width of a port index.
- WDOG_CYCLES, 64, watchdog stall limit in cycles; used only when the optional feature is compiled in.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  [N]  in_valid[i]: input i presents a beat
- in_dest  input  ROUTE_BITS x [N]  in_dest[i]: destination output of input i; stable while in_valid[i]=1
- in_last  input  [N]  in_last[i]: current beat is the last of the packet
- in_ready  output  [N]  in_ready[i]: beat of input i accepted this cycle
- out_ready  input  [N]  out_ready[j]: output j can accept a beat
- route  output  ROUTE_BITS x [N]  route[j]: input index connected to output j
- route_valid  output  [N]  route_valid[j]: output j is locked and route[j] is meaningful
- wdog_err  output  [N]  wdog_err[j]: one-cycle pulse on watchdog release (tied to 0 without the feature)

Behaviour:
- Reset (rst=1 at a clock edge): all outputs IDLE; rr_ptr[j]=0; route[j]=0; route_valid[j]=0; wdog_err=0. in_ready=0 from the first cycle after the reset edge. Reset mid-packet abandons the packet with no flush.
- Request vector per output: req_j[i] = in_valid[i] & (in_dest[i]==j) & ~busy[i]. busy[i] is set while input i owns any output.
- Per-output FSM, IDLE to LOCKED:
  - If req_j != 0, pick the first set bit scanning from rr_ptr[j] upward with wrap N-1 to 0.
  - Next cycle: route[j]=winner, route_valid[j]=1, busy[winner]=1.
  - Latency from in_valid to grant is 1 cycle; the first beat can be accepted in the cycle route_valid rises.
- Per-output FSM, LOCKED:
  - in_ready[owner] = in_valid[owner] & out_ready[j]. This is combinational, so zero-cycle backpressure applies.
  - Transfer happens when in_valid & in_ready.
  - A transfer with in_last=1 moves the FSM to IDLE next cycle: route_valid[j]=0, busy cleared, rr_ptr[j]=(owner+1) mod N.
  - route[j] holds its last value while IDLE.
- One bubble cycle follows every release; a new grant appears at release+2 at the earliest.
- Only one FSM can accept a given input. in_dest is a single index and busy[] blocks multiple ownership, so every in_ready bit has at most one driver.
- in_dest changing while its input is the owner is a protocol violation. The lock uses the latched binding and ignores in_dest.
- Single-beat packets (in_valid and in_last on the first beat) are legal: grant, one transfer, release.
- Two outputs granting in the same cycle is legal and independent. Two inputs targeting the same output are served in round-robin order.
- Simultaneous events at one input (release and a new request in the same cycle): release completes first; the new request is arbitrated from the IDLE state next cycle.
- in_ready[i]=0 for any input that is not an owner.

Optional Feature:
- Macro: XBAR_SCHED_WATCHDOG_EN.
- Defined: each LOCKED output keeps a stall counter. The counter resets on every transfer or on entry to LOCKED, and increments on cycles with no transfer. When it reaches WDOG_CYCLES-1 the output is force-released to IDLE, as if in_last had been seen, and wdog_err[j] pulses for 1 cycle.
- Not defined: no counter logic; wdog_err is tied to 0; a locked output waits indefinitely.

Test Plan:
- Reset then idle: rst for 2 cycles, all inputs idle -> route=0, route_valid=0, in_ready=0, wdog_err=0.
- Single grant: input 3, dest=5, 4-beat packet, out_ready[5]=1 -> route_valid[5] rises 1 cycle after in_valid; route[5]=3; 4 consecutive in_ready[3] pulses; route_valid[5] falls the cycle after the last beat.
- Round-robin fairness: inputs 0, 2 and 6 all dest=1 with continuous 1-beat packets -> grant order 0, 2, 6, 0, ...; one bubble between grants; no input skipped.
- Backpressure: owner 4 to output 7, out_ready[7] toggles 1,0,0,1 -> in_ready[4] follows out_ready the same cycle; beat count preserved; route_valid[7] held throughout.
- Parallel paths: inputs 0 to 3 with dest=3,2,1,0 simultaneously -> all four route_valid set in the same cycle; route[3]=0, route[2]=1, route[1]=2, route[0]=3.
- Watchdog (XBAR_SCHED_WATCHDOG_EN, WDOG_CYCLES=8): owner holds in_valid=0 after the first beat with no in_last -> release after 8 stall cycles; wdog_err[j] pulses once; a waiting input is granted 2 cycles later.

Source files
------------

// File: rtl/xbar_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : xbar_rr_scheduler
// Purpose  : Per-output round-robin scheduler for an NxN crossbar. Every
//            output arbitrates among the inputs that target it and locks the
//            winner until the packet's last beat. It drives the per-output
//            route index and gates input ready with output backpressure.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            in_valid[N]      - input i presents a beat
//            in_dest[N*RB]    - destination output of input i (RB = $clog2(N))
//            in_last[N]       - beat is the last of its packet
//            in_ready[N]      - beat of input i accepted this cycle
//            out_ready[N]     - output j can accept a beat
//            route[N*RB]      - input index connected to output j
//            route_valid[N]   - output j is locked, route[j] meaningful
//            wdog_err[N]      - one-cycle pulse on a watchdog release
// Options  : XBAR_SCHED_WATCHDOG_EN - force-release an output that has seen
//            no transfer for WDOG_CYCLES cycles. Without it wdog_err is 0.
// Revision : 1.0 - initial release
// ============================================================================
module xbar_rr_scheduler #(
    parameter int N           = 8,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           in_valid,
    input  logic [N*$clog2(N)-1:0] in_dest,
    input  logic [N-1:0]           in_last,
    output logic [N-1:0]           in_ready,
    input  logic [N-1:0]           out_ready,
    output logic [N*$clog2(N)-1:0] route,
    output logic [N-1:0]           route_valid,
    output logic [N-1:0]           wdog_err
);

    localparam int ROUTE_BITS = $clog2(N);
    localparam int c_SUM_W    = ROUTE_BITS + 1;

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    // N < 2 or WDOG_CYCLES < 2 are unsupported configurations.
    generate
        if (N < 2 || WDOG_CYCLES < 2) begin : g_cfg_unsupported
        end
    endgenerate

    logic [N-1:0]                 r_state;
    logic [N-1:0]                 w_state_nxt;
    logic [N-1:0][ROUTE_BITS-1:0] r_route;
    logic [N-1:0][ROUTE_BITS-1:0] w_route_nxt;
    logic [N-1:0][ROUTE_BITS-1:0] r_rr_ptr;
    logic [N-1:0][ROUTE_BITS-1:0] w_rr_ptr_nxt;
    logic [N-1:0][ROUTE_BITS-1:0] w_dest;

    logic [N-1:0] w_busy;
    logic [N-1:0] w_xfer;
    logic [N-1:0] w_last_xfer;
    logic [N-1:0] w_wdog_fire;
    logic [N-1:0] w_release;

    logic                  w_found;
    logic [c_SUM_W-1:0]    w_sum;
    logic [ROUTE_BITS-1:0] w_cand;

    assign w_dest = in_dest;

    // Ownership decode from the latched binding; in_dest of an owner is
    // deliberately not consulted here.
    always_comb begin
        w_busy      = '0;
        w_xfer      = '0;
        w_last_xfer = '0;
        for (int j = 0; j < N; j++) begin
            if (r_state[j] == c_ST_LOCKED) begin
                w_busy[r_route[j]] = 1'b1;
                w_xfer[j]          = in_valid[r_route[j]] & out_ready[j];
                w_last_xfer[j]     = w_xfer[j] & in_last[r_route[j]];
            end
        end
    end

`ifdef XBAR_SCHED_WATCHDOG_EN
    localparam int                  c_WDOG_W   = $clog2(WDOG_CYCLES + 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_MAX = c_WDOG_W'(WDOG_CYCLES - 1);

    logic [N-1:0][c_WDOG_W-1:0] r_wdog_cnt;
    logic [N-1:0]               r_wdog_err;

    // Fires on the WDOG_CYCLES-th consecutive cycle without a transfer.
    always_comb begin
        w_wdog_fire = '0;
        for (int j = 0; j < N; j++) begin
            w_wdog_fire[j] = (r_state[j] == c_ST_LOCKED) & ~w_xfer[j] &
                             (r_wdog_cnt[j] == c_WDOG_MAX);
        end
    end

    // Counter stays at zero while IDLE, so entry to LOCKED starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= '0;
        end else begin
            r_wdog_err <= w_wdog_fire;
            for (int j = 0; j < N; j++) begin
                if (r_state[j] != c_ST_LOCKED || w_xfer[j] || w_wdog_fire[j]) begin
                    r_wdog_cnt[j] <= '0;
                end else begin
                    r_wdog_cnt[j] <= r_wdog_cnt[j] + 1'b1;
                end
            end
        end
    end

    assign wdog_err = r_wdog_err;
`else
    assign w_wdog_fire = '0;
    assign wdog_err    = '0;
`endif

    assign w_release = w_last_xfer | w_wdog_fire;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= {N{c_ST_IDLE}};
            r_route  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_route  <= w_route_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // Next-state: IDLE outputs scan from rr_ptr upward with wrap; LOCKED
    // outputs release on a last-beat transfer (or watchdog) and advance the
    // pointer past the released owner. The releasing input is still busy in
    // that cycle, so a new request from it is only seen once IDLE.
    always_comb begin
        w_state_nxt  = r_state;
        w_route_nxt  = r_route;
        w_rr_ptr_nxt = r_rr_ptr;
        w_found      = 1'b0;
        w_sum        = '0;
        w_cand       = '0;
        for (int j = 0; j < N; j++) begin
            if (r_state[j] == c_ST_IDLE) begin
                w_found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    w_sum = {1'b0, r_rr_ptr[j]} + c_SUM_W'(k);
                    if (w_sum >= c_SUM_W'(N)) begin
                        w_sum = w_sum - c_SUM_W'(N);
                    end
                    w_cand = w_sum[ROUTE_BITS-1:0];
                    if (!w_found && in_valid[w_cand] && !w_busy[w_cand] &&
                        (w_dest[w_cand] == ROUTE_BITS'(j))) begin
                        w_found        = 1'b1;
                        w_state_nxt[j] = c_ST_LOCKED;
                        w_route_nxt[j] = w_cand;
                    end
                end
            end else if (w_release[j]) begin
                w_state_nxt[j]  = c_ST_IDLE;
                w_rr_ptr_nxt[j] = (r_route[j] == ROUTE_BITS'(N - 1)) ? '0
                                                                     : r_route[j] + 1'b1;
            end
        end
    end

    // Outputs: ready is combinational so backpressure takes effect in the
    // same cycle. busy[] guarantees at most one output drives each bit.
    always_comb begin
        in_ready    = '0;
        route_valid = '0;
        route       = r_route;
        for (int j = 0; j < N; j++) begin
            route_valid[j] = (r_state[j] == c_ST_LOCKED);
            if (r_state[j] == c_ST_LOCKED && out_ready[j]) begin
                in_ready[r_route[j]] = in_valid[r_route[j]];
            end
        end
    end

endmodule
`default_nettype wire
